// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared constants and types for the decode-stage hazard
//               controller: register address width, architectural register
//               count and the hard-wired zero register index.
// Revision    : 1.0  initial release
// ============================================================================
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_vec_t;

    localparam reg_addr_t X0 = 5'd0;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_detection_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit_if
// Description : Bundle of pipeline-side signals seen by the hazard controller.
//               master : pipeline side (drives decode/EX/long-unit status,
//                        receives stall/flush controls and Busy)
//               slave  : hazard_detection_unit
//               Stall_Count exists only when HAZARD_STALL_CNT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
interface hazard_detection_unit_if;
    import hazard_pkg::*;

    // Decode-stage instruction
    reg_addr_t IF_ID_RS1;
    reg_addr_t IF_ID_RS2;
    logic      IF_ID_UsesRS1;
    logic      IF_ID_UsesRS2;
    reg_addr_t IF_ID_RD;
    logic      IF_ID_RegWrite;
    logic      IF_ID_IsLong;
    // Execute-stage instruction
    logic      ID_EX_MemRead;
    reg_addr_t ID_EX_RD;
    logic      EX_LongIssue;
    // Long-latency unit status
    logic      Long_Ready;
    logic      Long_Done;
    reg_addr_t Long_RD;
    // Control flow
    logic      Branch_Taken;
    // Controls back to the pipeline
    logic      PCWrite;
    logic      IF_ID_Write;
    logic      ID_EX_Bubble;
    logic      IF_ID_Flush;
    reg_vec_t  Busy;
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] Stall_Count;
`endif

    modport master (
        output IF_ID_RS1, IF_ID_RS2, IF_ID_UsesRS1, IF_ID_UsesRS2,
               IF_ID_RD, IF_ID_RegWrite, IF_ID_IsLong,
               ID_EX_MemRead, ID_EX_RD, EX_LongIssue,
               Long_Ready, Long_Done, Long_RD, Branch_Taken,
        input  PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Busy
`ifdef HAZARD_STALL_CNT_EN
        , input Stall_Count
`endif
    );

    modport slave (
        input  IF_ID_RS1, IF_ID_RS2, IF_ID_UsesRS1, IF_ID_UsesRS2,
               IF_ID_RD, IF_ID_RegWrite, IF_ID_IsLong,
               ID_EX_MemRead, ID_EX_RD, EX_LongIssue,
               Long_Ready, Long_Done, Long_RD, Branch_Taken,
        output PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush, Busy
`ifdef HAZARD_STALL_CNT_EN
        , output Stall_Count
`endif
    );

endinterface : hazard_detection_unit_if
`default_nettype wire

// File: rtl/hazard_detection_unit_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy bits for results still in flight on the
//               long-latency unit.
//   clk       in   pipeline clock
//   rst       in   synchronous active-low reset, clears every bit
//   set_en    in   mark set_addr busy at the next edge
//   set_addr  in   register to mark
//   clr_en    in   release clr_addr at the next edge
//   clr_addr  in   register to release
//   busy      out  busy vector, bit 0 always 0
// Revision    : 1.0  initial release
// ============================================================================
module reg_scoreboard
    import hazard_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      set_en,
    input  wire reg_addr_t set_addr,
    input  wire logic      clr_en,
    input  wire reg_addr_t clr_addr,
    output reg_vec_t       busy
);

    reg_vec_t r_busy;
    reg_vec_t w_busy_nxt;

    always_comb begin
        w_busy_nxt = r_busy;
        // Clear first so a same-cycle set of the same register wins.
        if (clr_en) begin
            w_busy_nxt[clr_addr] = 1'b0;
        end
        if (set_en) begin
            w_busy_nxt[set_addr] = 1'b1;
        end
        // x0 is never a real destination.
        w_busy_nxt[X0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign busy = r_busy;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detection_unit
// Description : Decode-stage stall/flush controller. Detects load-use,
//               read/write of registers pending on the long unit, the long
//               unit structural hazard and taken-branch flush, and drives
//               PC / IF_ID enables, ID_EX bubble and IF_ID flush.
//   clk   in   pipeline clock
//   rst   in   synchronous active-low reset
//   bus   slave modport of hazard_detection_unit_if (all pipeline signals,
//         Busy vector, and Stall_Count when enabled)
// Optional    : HAZARD_STALL_CNT_EN adds the saturating Stall_Count counter.
// Revision    : 1.0  initial release
// ============================================================================
module hazard_detection_unit
    import hazard_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    hazard_detection_unit_if.slave  bus
);

    reg_vec_t w_busy;
    logic     w_load_use;
    logic     w_raw_busy;
    logic     w_waw_busy;
    logic     w_struct;
    logic     w_stall;
    logic     w_issue_set;

    assign w_issue_set = bus.EX_LongIssue && (bus.ID_EX_RD != X0);

    reg_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (w_issue_set),
        .set_addr (bus.ID_EX_RD),
        .clr_en   (bus.Long_Done),
        .clr_addr (bus.Long_RD),
        .busy     (w_busy)
    );

    // Loaded value is not forwardable until it leaves MEM: one bubble.
    assign w_load_use = bus.ID_EX_MemRead && (bus.ID_EX_RD != X0) &&
                        ((bus.IF_ID_UsesRS1 && (bus.IF_ID_RS1 == bus.ID_EX_RD)) ||
                         (bus.IF_ID_UsesRS2 && (bus.IF_ID_RS2 == bus.ID_EX_RD)));

    assign w_raw_busy = (bus.IF_ID_UsesRS1 && w_busy[bus.IF_ID_RS1]) ||
                        (bus.IF_ID_UsesRS2 && w_busy[bus.IF_ID_RS2]);

    // A later writer must not overtake the pending long-op writeback.
    assign w_waw_busy = bus.IF_ID_RegWrite && (bus.IF_ID_RD != X0) &&
                        w_busy[bus.IF_ID_RD];

    assign w_struct   = bus.IF_ID_IsLong && !bus.Long_Ready;

    assign w_stall    = w_load_use || w_raw_busy || w_waw_busy || w_struct;

    always_comb begin
        bus.PCWrite      = 1'b1;
        bus.IF_ID_Write  = 1'b1;
        bus.ID_EX_Bubble = 1'b0;
        bus.IF_ID_Flush  = 1'b0;
        if (bus.Branch_Taken) begin
            // Wrong-path instruction in decode is squashed, so its stall is moot.
            bus.IF_ID_Flush  = 1'b1;
            bus.ID_EX_Bubble = 1'b1;
        end else if (w_stall) begin
            bus.PCWrite      = 1'b0;
            bus.IF_ID_Write  = 1'b0;
            bus.ID_EX_Bubble = 1'b1;
        end
    end

    assign bus.Busy = w_busy;

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (w_stall && !bus.Branch_Taken && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign bus.Stall_Count = r_stall_count;
`endif

endmodule : hazard_detection_unit
`default_nettype wire

// File: tb/tb_hazard_detection_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_detection_unit
// Description : Self-checking bench for hazard_detection_unit. Vector table
//               for the combinational hazard equations, plus directed
//               sequences for load-use release, long-op scoreboard, the
//               structural hazard, branch priority and reset.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_detection_unit;
    import hazard_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    hazard_detection_unit_if hif ();

    hazard_detection_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       islong;
        logic       memrd;
        logic [4:0] exrd;
        logic       lready;
        logic       btaken;
        logic [3:0] exp;   // {PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}
        string      name;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_ctl(input string name, input logic [3:0] exp);
        chk(name, {28'd0, hif.PCWrite, hif.IF_ID_Write, hif.ID_EX_Bubble, hif.IF_ID_Flush},
            {28'd0, exp});
    endtask

    task automatic idle();
        hif.IF_ID_RS1      = 5'd0;
        hif.IF_ID_RS2      = 5'd0;
        hif.IF_ID_UsesRS1  = 1'b0;
        hif.IF_ID_UsesRS2  = 1'b0;
        hif.IF_ID_RD       = 5'd0;
        hif.IF_ID_RegWrite = 1'b0;
        hif.IF_ID_IsLong   = 1'b0;
        hif.ID_EX_MemRead  = 1'b0;
        hif.ID_EX_RD       = 5'd0;
        hif.EX_LongIssue   = 1'b0;
        hif.Long_Ready     = 1'b1;
        hif.Long_Done      = 1'b0;
        hif.Long_RD        = 5'd0;
        hif.Branch_Taken   = 1'b0;
    endtask

    // Advance one edge; inputs change and checks happen 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b0;
        idle();

        //                rs1   rs2   u1 u2 rd    rw lg mr exrd  lr bt  exp
        vecs[0] = '{5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 1, 5'd5, 1, 0, 4'b0010, "lu_rs1"};
        vecs[1] = '{5'd5, 5'd5, 0, 1, 5'd6, 1, 0, 1, 5'd5, 1, 0, 4'b0010, "lu_rs2"};
        vecs[2] = '{5'd5, 5'd1, 0, 1, 5'd6, 1, 0, 1, 5'd5, 1, 0, 4'b1100, "lu_rs1_unused"};
        vecs[3] = '{5'd0, 5'd0, 1, 1, 5'd6, 1, 0, 1, 5'd0, 1, 0, 4'b1100, "lu_x0"};
        vecs[4] = '{5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 0, 5'd5, 1, 0, 4'b1100, "no_load"};
        vecs[5] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 0, 5'd0, 0, 0, 4'b0010, "struct"};
        vecs[6] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 1, 0, 5'd0, 1, 0, 4'b1100, "long_ready"};
        vecs[7] = '{5'd5, 5'd1, 1, 1, 5'd6, 1, 0, 1, 5'd5, 1, 1, 4'b1111, "br_over_lu"};
        vecs[8] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 5'd0, 1, 1, 4'b1111, "br_only"};
        vecs[9] = '{5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 5'd4, 1, 0, 4'b1100, "no_hazard"};

        // ---- reset state ----
        step();
        rst = 1'b1;
        #1;
        chk("rst_busy", hif.Busy, 32'h0);
        chk_ctl("rst_ctl", 4'b1100);
`ifdef HAZARD_STALL_CNT_EN
        chk("rst_cnt", hif.Stall_Count, 32'd0);
`endif

        // ---- table vectors (Busy is all zero, no issue) ----
        for (int i = 0; i < 10; i++) begin
            hif.IF_ID_RS1      = vecs[i].rs1;
            hif.IF_ID_RS2      = vecs[i].rs2;
            hif.IF_ID_UsesRS1  = vecs[i].u1;
            hif.IF_ID_UsesRS2  = vecs[i].u2;
            hif.IF_ID_RD       = vecs[i].rd;
            hif.IF_ID_RegWrite = vecs[i].rw;
            hif.IF_ID_IsLong   = vecs[i].islong;
            hif.ID_EX_MemRead  = vecs[i].memrd;
            hif.ID_EX_RD       = vecs[i].exrd;
            hif.Long_Ready     = vecs[i].lready;
            hif.Branch_Taken   = vecs[i].btaken;
            #1;
            chk_ctl(vecs[i].name, vecs[i].exp);
            step();
        end
`ifdef HAZARD_STALL_CNT_EN
        // Stalls without branch in vectors 0, 1 and 5.
        chk("tbl_cnt", hif.Stall_Count, 32'd3);
`endif
        idle();
        do_reset();

        // ---- load-use: one cycle stall, then released ----
        hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RD = 5'd5;
        hif.IF_ID_RS1 = 5'd5; hif.IF_ID_UsesRS1 = 1'b1;
        hif.IF_ID_RS2 = 5'd1; hif.IF_ID_UsesRS2 = 1'b1;
        hif.IF_ID_RD = 5'd6; hif.IF_ID_RegWrite = 1'b1;
        #1;
        chk_ctl("lu_stall", 4'b0010);
        step();
        hif.ID_EX_MemRead = 1'b0; hif.ID_EX_RD = 5'd0;
        #1;
        chk_ctl("lu_release", 4'b1100);
        step();
        idle();

        // ---- long op to x7, consumer stalls until after Long_Done ----
        hif.EX_LongIssue = 1'b1; hif.ID_EX_RD = 5'd7;
        step();
        hif.EX_LongIssue = 1'b0; hif.ID_EX_RD = 5'd0;
        chk("long_busy_set", hif.Busy, 32'h0000_0080);
        hif.IF_ID_RS2 = 5'd7; hif.IF_ID_UsesRS2 = 1'b1;
        #1;
        chk_ctl("long_raw_stall", 4'b0010);
        step();
        chk_ctl("long_raw_stall2", 4'b0010);
        hif.Long_Done = 1'b1; hif.Long_RD = 5'd7;
        #1;
        chk_ctl("long_done_cycle", 4'b0010);
        step();
        hif.Long_Done = 1'b0; hif.Long_RD = 5'd0;
        #1;
        chk("long_busy_clr", hif.Busy, 32'h0);
        chk_ctl("long_release", 4'b1100);
        idle();

        // ---- WAW on a busy destination ----
        hif.EX_LongIssue = 1'b1; hif.ID_EX_RD = 5'd7;
        step();
        idle();
        hif.IF_ID_RD = 5'd7; hif.IF_ID_RegWrite = 1'b1;
        #1;
        chk_ctl("waw_stall", 4'b0010);

        // ---- reset mid-operation discards Busy ----
        chk("pre_rst_busy", hif.Busy, 32'h0000_0080);
        idle();
        do_reset();
        chk("mid_rst_busy", hif.Busy, 32'h0);
        chk_ctl("mid_rst_ctl", 4'b1100);
`ifdef HAZARD_STALL_CNT_EN
        chk("mid_rst_cnt", hif.Stall_Count, 32'd0);
`endif

        // ---- same-cycle set and clear of x9, issue to x0 ----
        hif.EX_LongIssue = 1'b1; hif.ID_EX_RD = 5'd9;
        hif.Long_Done = 1'b1; hif.Long_RD = 5'd9;
        step();
        chk("set_wins", hif.Busy, 32'h0000_0200);
        hif.ID_EX_RD = 5'd0; hif.Long_Done = 1'b0;
        step();
        chk("issue_x0", hif.Busy, 32'h0000_0200);
        hif.EX_LongIssue = 1'b0;
        hif.Long_Done = 1'b1; hif.Long_RD = 5'd9;
        step();
        chk("clr_x9", hif.Busy, 32'h0);
        idle();

        // ---- structural hazard for 3 cycles, then branch + load-use ----
        do_reset();
        hif.IF_ID_IsLong = 1'b1; hif.Long_Ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_ctl("struct_seq", 4'b0010);
            step();
        end
        hif.Long_Ready = 1'b1;
        #1;
        chk_ctl("struct_release", 4'b1100);
`ifdef HAZARD_STALL_CNT_EN
        chk("struct_cnt", hif.Stall_Count, 32'd3);
`endif
        idle();
        hif.ID_EX_MemRead = 1'b1; hif.ID_EX_RD = 5'd5;
        hif.IF_ID_RS1 = 5'd5; hif.IF_ID_UsesRS1 = 1'b1;
        hif.Branch_Taken = 1'b1;
        #1;
        chk_ctl("br_lu_seq", 4'b1111);
        step();
`ifdef HAZARD_STALL_CNT_EN
        chk("br_no_cnt", hif.Stall_Count, 32'd3);
`endif
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_hazard_detection_unit
`default_nettype wire

// File: doc/hazard_detection_unit.md
# hazard_detection_unit

Decode-stage hazard controller for the 5-stage RISC-V pipeline; the stall/flush counterpart to operand forwarding. Forwarding resolves producer-to-consumer data hazards without delay; this block handles hazards that forwarding cannot cover: load-use, operands of multi-cycle (long-latency) ops, the long-unit structural hazard, and taken-branch flush. It holds a per-register busy scoreboard and drives PC/IF_ID write enables, ID_EX bubble insertion and IF_ID flush.

## Interface
- NUM_REGS, 32, architectural register count; index width 5.
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-low reset.
- IF_ID_RS1, IF_ID_RS2  in  5 each  source registers of the instruction in decode.
- IF_ID_UsesRS1, IF_ID_UsesRS2  in  1 each  the decoded instruction reads that source.
- IF_ID_RD  in  5  destination of the decode instruction.
- IF_ID_RegWrite  in  1  the decode instruction writes IF_ID_RD.
- IF_ID_IsLong  in  1  the decode instruction uses the long-latency unit.
- ID_EX_MemRead  in  1  the instruction in EX is a load.
- ID_EX_RD  in  5  destination of the instruction in EX.
- EX_LongIssue  in  1  the instruction in EX starts on the long unit this cycle.
- Long_Ready  in  1  the long unit accepts a new op.
- Long_Done  in  1  the long unit writes back this cycle.
- Long_RD  in  5  destination of the completing long op.
- Branch_Taken  in  1  taken branch/jump resolved in EX.
- PCWrite  out  1  PC update enable.
- IF_ID_Write  out  1  IF/ID register enable.
- ID_EX_Bubble  out  1  zero ID/EX control fields next edge.
- IF_ID_Flush  out  1  clear IF/ID next edge.
- Busy  out  32  scoreboard vector; bit 0 always 0.
- Stall_Count  out  32  present only with HAZARD_STALL_CNT_EN.

## Operation
- LoadUse = ID_EX_MemRead && ID_EX_RD!=0 && ((IF_ID_UsesRS1 && IF_ID_RS1==ID_EX_RD) || (IF_ID_UsesRS2 && IF_ID_RS2==ID_EX_RD)).
- RawBusy = (IF_ID_UsesRS1 && Busy[IF_ID_RS1]) || (IF_ID_UsesRS2 && Busy[IF_ID_RS2]).
- WawBusy = IF_ID_RegWrite && IF_ID_RD!=0 && Busy[IF_ID_RD].
- Struct = IF_ID_IsLong && !Long_Ready.
- Stall = LoadUse || RawBusy || WawBusy || Struct.
- Priority: Branch_Taken overrides Stall -> PCWrite=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1.
- Otherwise Stall -> PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
- Otherwise PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0.
- Scoreboard set: EX_LongIssue && ID_EX_RD!=0 sets Busy[ID_EX_RD] at the next edge.
- Scoreboard clear: Long_Done clears Busy[Long_RD] at the next edge.
- Set and clear of the same register in one cycle: set wins.
- Writes to x0 are ignored; Busy[0] is constant 0.

## Timing
- Stall/flush outputs are combinational from inputs and registered Busy, with no added latency.
- Load-use stall lasts exactly 1 cycle. The following cycle's forwarding handles the operand.
- A consumer of a long op is released in the cycle after Long_Done, when the Busy bit reads 0.
- Reset (rst=0 at an edge): Busy=0 and Stall_Count=0. Outputs then read PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0. Reset mid-operation discards all pending Busy bits.

## Configuration
- HAZARD_STALL_CNT_EN defined: Stall_Count increments by 1 on every cycle with Stall=1 and Branch_Taken=0, and saturates at 32'hFFFFFFFF.
- Macro absent: neither the Stall_Count port nor its counter exists.

## Structure
- hazard_pkg holds REG_ADDR_W=5, NUM_REGS=32 and the X0 constant.
- Sub-module reg_scoreboard holds the busy vector with its set/clear ports and set-wins resolution. The top level holds the hazard equations and the counter.

## Test plan
- Load x5 in EX, decode add x6,x5,x1 -> 1 cycle: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1. Next cycle, with the load no longer in EX: all released.
- EX_LongIssue with ID_EX_RD=7, then decode uses x7 -> stall until the cycle after Long_Done with Long_RD=7. Busy[7] goes 1 then 0.
- Decode IsLong with Long_Ready=0 for 3 cycles -> 3 stall cycles; Stall_Count=3 with the macro enabled.
- Branch_Taken together with a load-use condition -> IF_ID_Flush=1, PCWrite=1, ID_EX_Bubble=1, and no Stall_Count increment.
- Same-cycle set and clear of x9 -> Busy[9]=1. An issue to x0 -> Busy stays 0.
- rst=0 with Busy=32'h00000080 -> Busy=0 and Stall_Count=0 after the edge, and all outputs are at the no-stall values.
